// File: rtl/result_display_pkg.sv
// Shared display definitions: segment codes, digit symbol codes, converter FSM states
// and the double-dabble nibble correction step.
package result_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low (common anode)
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] SYM_MINUS = 4'd10;
  localparam logic [3:0] SYM_E     = 4'd11;
  localparam logic [3:0] SYM_R     = 4'd12;
  localparam logic [3:0] SYM_BLANK = 4'd15;

  localparam int BCD_W = 12;

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W/4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_display_if.sv
// Result hand-off from the controller plus the 7-segment drive lines.
// master = result producer, slave = display block.
interface result_display_if #(parameter int W = 4);
  logic [W-1:0] R0in;
  logic [W-1:0] R1in;
  logic         Mulmode;
  logic         Errin;
  logic         Start;
  logic         Busy;
  logic [3:0]   Anode;
  logic [6:0]   Seg;

  modport master (
    output R0in, R1in, Mulmode, Errin, Start,
    input  Busy, Anode, Seg
  );

  modport slave (
    input  R0in, R1in, Mulmode, Errin, Start,
    output Busy, Anode, Seg
  );
endinterface

// File: rtl/result_display_seg7_decode.sv
// Combinational map from 4-bit digit symbol code to active-low {g..a} segments.
// Unused codes show blank.
module seg7_decode
  import result_display_pkg::*;
(
  input  logic [3:0] sym,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (sym)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      SYM_MINUS: seg = SEG_MINUS;
      SYM_E:     seg = SEG_E;
      SYM_R:     seg = SEG_R;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// Signed result -> decimal by serial double-dabble (Busy 9 cycles after Start, Start ignored while Busy),
// shown on a free-running 4-digit multiplexed common-anode display.
module result_display
  import result_display_pkg::*;
#(
  parameter int W       = 4,
  parameter int REFRESH = 1000
) (
  input  logic             clk,
  input  logic             rstn,
  result_display_if.slave  bus
);

  localparam int PW = 2 * W;
  localparam int CW = (REFRESH > 2) ? $clog2(REFRESH) : 1;

  state_t               state;
  logic [2:0]           iter;
  logic                 err_q;
  logic                 sign_q;
  logic                 busy_q;
  logic [PW-1:0]        mag;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [3:0][3:0]      dig;
  logic [PW-1:0]        val;
  logic [PW-1:0]        val_abs;

  always_comb begin
    val = bus.Mulmode ? {bus.R1in, bus.R0in} : {{W{bus.R0in[W-1]}}, bus.R0in};
    // -128 maps to 8'h80, which read unsigned is the wanted magnitude 128
    val_abs = val[PW-1] ? (~val + PW'(1)) : val;
    bcd_adj = dd_adjust(bcd);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      iter   <= 3'd0;
      err_q  <= 1'b0;
      sign_q <= 1'b0;
      busy_q <= 1'b0;
      mag    <= '0;
      bcd    <= '0;
      dig    <= {SYM_BLANK, SYM_BLANK, SYM_BLANK, 4'd0};
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            err_q  <= bus.Errin;
            sign_q <= val[PW-1];
            mag    <= val_abs;
            bcd    <= '0;
            iter   <= 3'd7;
            busy_q <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          bcd <= {bcd_adj[BCD_W-2:0], mag[PW-1]};
          mag <= {mag[PW-2:0], 1'b0};
          if (iter == 3'd0) state <= LOAD;
          else              iter  <= iter - 3'd1;
        end
        LOAD: begin
          if (err_q) begin
            dig <= {SYM_BLANK, SYM_E, SYM_R, SYM_R};
          end else begin
            dig[3] <= sign_q ? SYM_MINUS : SYM_BLANK;
            dig[2] <= (bcd[11:8] == 4'd0) ? SYM_BLANK : bcd[11:8];
            dig[1] <= (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? SYM_BLANK : bcd[7:4];
            dig[0] <= bcd[3:0];
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    anode_q;
  logic [6:0]    seg_q;
  logic [6:0]    seg_nxt;

  seg7_decode u_dec (
    .sym (dig[idx]),
    .seg (seg_nxt)
  );

  // Scan never stalls; digit registers only change in LOAD, so no partial values show
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      idx     <= 2'd0;
      anode_q <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      if (cnt == CW'(REFRESH - 1)) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      anode_q <= ~(4'b0001 << idx);
      seg_q   <= seg_nxt;
    end
  end

  assign bus.Busy  = busy_q;
  assign bus.Anode = anode_q;
  assign bus.Seg   = seg_q;

endmodule
